// File: rtl/systolic_output_drain_pkg.sv
// Shared defaults and arithmetic helpers for the systolic array output path.
// sat_add is width-generic so other LeNet stages can reuse it.
package systolic_output_drain_pkg;

  localparam int DATA_W    = 16;
  localparam int TILE_SIZE = 4;
  localparam int IDX_W     = $clog2(TILE_SIZE * TILE_SIZE);

  // Operands arrive sign-extended to 64 bits; the result is clamped to a signed w-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/systolic_output_drain_postproc.sv
// Combinational bias add, saturation to N bits, then optional ReLU.
module drain_postproc
  import systolic_output_drain_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic signed [N-1:0] z,
  input  logic signed [N-1:0] bias,
  input  logic                relu_en,
  output logic        [N-1:0] result
);

  logic signed [63:0] sum_sat;

  always_comb begin
    sum_sat = sat_add(64'(z), 64'(bias), N);
    result  = (relu_en && (sum_sat < 64'sd0)) ? '0 : sum_sat[N-1:0];
  end

endmodule

// File: rtl/systolic_output_drain.sv
// Captures flattened Z tiles into a two-slot buffer and streams them row-major,
// one post-processed element per valid/ready handshake; tiles with no free slot are dropped.
module systolic_output_drain
  import systolic_output_drain_pkg::*;
#(
  parameter int N    = DATA_W,
  parameter int SIZE = TILE_SIZE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N*SIZE*SIZE-1:0]        Z_in,
  input  logic                          z_valid,
  input  logic [N-1:0]                  bias,
  input  logic                          relu_en,
  input  logic                          out_ready,
  input  logic                          clear_ovf,
  output logic [N-1:0]                  out_data,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [$clog2(SIZE*SIZE)-1:0]  out_idx,
  output logic                          buf_full,
  output logic                          overflow
);

  localparam int              ELEMS    = SIZE * SIZE;
  localparam int              IW       = $clog2(ELEMS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(ELEMS - 1);

  logic [N*ELEMS-1:0] tile_q [2];
  logic [N-1:0]       bias_q [2];
  logic               relu_q [2];

  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [IW-1:0] elem_cnt;

  logic          load;
  logic          rel;
  logic          accept;
  logic          drop;
  logic [N-1:0]  elem;
  logic [N-1:0]  pp_result;

  // A full buffer can still take a tile in the cycle its oldest tile releases.
  always_comb begin
    load      = (count != 2'd0) && (!out_valid || out_ready);
    rel       = load && (elem_cnt == LAST_IDX);
    accept    = z_valid && ((count != 2'd2) || rel);
    drop      = z_valid && !accept;
    count_nxt = count;
    if (accept && !rel)      count_nxt = count + 2'd1;
    else if (rel && !accept) count_nxt = count - 2'd1;
    elem      = tile_q[rd_ptr][int'(elem_cnt) * N +: N];
  end

  drain_postproc #(.N(N)) u_postproc (
    .z       (elem),
    .bias    (bias_q[rd_ptr]),
    .relu_en (relu_q[rd_ptr]),
    .result  (pp_result)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      tile_q[wr_ptr] <= Z_in;
      bias_q[wr_ptr] <= bias;
      relu_q[wr_ptr] <= relu_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      elem_cnt  <= '0;
      buf_full  <= 1'b0;
      overflow  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else begin
      count    <= count_nxt;
      buf_full <= (count_nxt == 2'd2);
      if (accept) wr_ptr <= ~wr_ptr;
      if (rel)    rd_ptr <= ~rd_ptr;

      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= pp_result;
        out_idx   <= elem_cnt;
        out_last  <= (elem_cnt == LAST_IDX);
        elem_cnt  <= rel ? '0 : elem_cnt + IW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_output_drain.sv
// Scoreboard bench for systolic_output_drain: directed tiles, backpressure, overflow, reset.
module tb_systolic_output_drain;

  localparam int N = 16;
  localparam int SIZE = 4;
  localparam int ELEMS = SIZE * SIZE;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [N*ELEMS-1:0]   Z_in = '0;
  logic                 z_valid = 1'b0;
  logic [N-1:0]         bias = '0;
  logic                 relu_en = 1'b0;
  logic                 out_ready = 1'b0;
  logic                 clear_ovf = 1'b0;
  logic [N-1:0]         out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [3:0]           out_idx;
  logic                 buf_full;
  logic                 overflow;

  always #5 clk = ~clk;

  systolic_output_drain #(.N(N), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .Z_in(Z_in), .z_valid(z_valid), .bias(bias),
    .relu_en(relu_en), .out_ready(out_ready), .clear_ovf(clear_ovf),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_idx(out_idx), .buf_full(buf_full), .overflow(overflow)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: handshakes are decided by values visible at the falling edge.
  logic        stalled = 1'b0;
  logic [15:0] sd;
  logic [3:0]  si;
  logic        sl;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_data", out_data, sd);
        check("stall_idx", out_idx, si);
        check("stall_last", out_last, sl);
      end
      stalled = out_valid && !out_ready;
      sd = out_data; si = out_idx; sl = out_last;
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got idx %0d data %0h expected no output", out_idx, out_data);
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_idx", out_idx, e.idx);
          check("out_last", out_last, e.last);
        end
      end
    end
  end

  function automatic logic [N*ELEMS-1:0] tile_fn(input int base, input int step);
    logic [N*ELEMS-1:0] t;
    for (int k = 0; k < ELEMS; k++) t[k*N +: N] = 16'(base + step * k);
    return t;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] z, input logic [15:0] b, input logic r);
    int s;
    s = int'($signed(z)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (r && s < 0) s = 0;
    return s[15:0];
  endfunction

  task automatic push_model(input logic [N*ELEMS-1:0] z, input logic [15:0] b, input logic r);
    for (int k = 0; k < ELEMS; k++)
      q.push_back('{data: model(z[k*N +: N], b, r), idx: 4'(k), last: (k == ELEMS - 1)});
  endtask

  task automatic push_const(input logic [15:0] v);
    for (int k = 0; k < ELEMS; k++)
      q.push_back('{data: v, idx: 4'(k), last: (k == ELEMS - 1)});
  endtask

  task automatic strobe(input logic [N*ELEMS-1:0] z, input logic [15:0] b, input logic r);
    Z_in = z; bias = b; relu_en = r; z_valid = 1'b1;
    @(posedge clk); #1;
    z_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_buf_full"}, buf_full, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    logic [N*ELEMS-1:0] ta;
    logic [N*ELEMS-1:0] tb;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Single ramp tile: outputs equal the element index
    out_ready = 1'b1;
    for (int k = 0; k < ELEMS; k++)
      q.push_back('{data: 16'(k), idx: 4'(k), last: (k == 15)});
    strobe(tile_fn(0, 1), 16'h0000, 1'b0);
    check("first_valid_pre", out_valid, 0);
    @(posedge clk); #1;
    check("first_valid", out_valid, 1);
    check("first_idx", out_idx, 0);
    drain(40);
    repeat (2) @(posedge clk); #1;
    check("idle_valid", out_valid, 0);
    check("t1_count", n_out, 16);

    // Saturation and ReLU corners, two tiles per batch
    strobe(tile_fn(16'h7FF0, 0), 16'h0020, 1'b0); push_const(16'h7FFF);
    strobe(tile_fn(16'h8005, 0), 16'hFFF0, 1'b0); push_const(16'h8000);
    drain(60);
    strobe(tile_fn(16'hFFFD, 0), 16'h0000, 1'b1); push_const(16'h0000);
    strobe(tile_fn(16'hFFFD, 0), 16'h0000, 1'b0); push_const(16'hFFFD);
    drain(60);

    // Random backpressure across two tiles with different bias
    out_ready = 1'b0;
    ta = tile_fn(16'h0100, 3);
    tb = tile_fn(-8, 4);
    strobe(ta, 16'h0010, 1'b0); push_model(ta, 16'h0010, 1'b0);
    strobe(tb, 16'hFFF8, 1'b1); push_model(tb, 16'hFFF8, 1'b1);
    n = 0;
    while (q.size() != 0 && n < 600) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("bp_drain_empty", q.size(), 0);
    out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Overflow: third back-to-back tile is dropped
    ta = tile_fn(16'h1000, 1);
    tb = tile_fn(16'h2000, 2);
    strobe(ta, 16'h0001, 1'b0);
    check("ovf_full_1", buf_full, 0);
    strobe(tb, 16'h0002, 1'b0);
    check("ovf_full_2", buf_full, 1);
    check("ovf_flag_2", overflow, 0);
    strobe(tile_fn(16'h3000, 1), 16'h0003, 1'b0);
    check("ovf_flag_3", overflow, 1);
    check("ovf_full_3", buf_full, 1);
    push_model(ta, 16'h0001, 1'b0);
    push_model(tb, 16'h0002, 1'b0);
    n0 = n_out;
    out_ready = 1'b1;
    drain(100);
    repeat (4) @(posedge clk); #1;
    check("ovf_elem_count", n_out - n0, 32);
    check("ovf_sticky", overflow, 1);
    clear_ovf = 1'b1;
    @(posedge clk); #1;
    clear_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Capture coinciding with release of the last element while full
    out_ready = 1'b0;
    ta = tile_fn(16'h0200, 1);
    tb = tile_fn(16'h0300, 1);
    strobe(ta, 16'h0000, 1'b0); push_model(ta, 16'h0000, 1'b0);
    strobe(tb, 16'h0005, 1'b0); push_model(tb, 16'h0005, 1'b0);
    check("sim_full_pre", buf_full, 1);
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_idx == 4'd14) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("sim_reach_idx14", out_idx, 14);
    ta = tile_fn(16'h0400, 2);
    strobe(ta, 16'h0001, 1'b1); push_model(ta, 16'h0001, 1'b1);
    check("sim_overflow", overflow, 0);
    check("sim_full_post", buf_full, 1);
    drain(80);

    // Reset in the middle of a tile
    ta = tile_fn(16'h0600, 1);
    strobe(ta, 16'h0000, 1'b0); push_model(ta, 16'h0000, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == 4'd7) && n < 50);
    check("rst_reach_idx7", out_idx, 7);
    #1 reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", out_valid, 0);
    ta = tile_fn(16'h0050, 1);
    strobe(ta, 16'hFFFF, 1'b0); push_model(ta, 16'hFFFF, 1'b0);
    drain(40);

    repeat (2) @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_output_drain.md
# systolic_output_drain

Downstream stage of the 4x4 systolic array wrapper. It captures each completed, flattened Z tile on the wrapper's one-cycle output-valid strobe and holds it in a two-slot tile buffer. It then serialises the tile row-major, one element per handshake, into the LeNet activation path. On the way out it applies a per-tile signed bias, saturation and optional ReLU. The array cannot be stalled, so tiles that arrive with no free slot are dropped and flagged.

## Interface
- N, 16: element width, signed two's complement
- SIZE, 4: tile dimension; a tile holds SIZE*SIZE elements
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Z_in  in  N*SIZE*SIZE  flattened tile; element k (k = row*SIZE+col) sits at bits [(k+1)*N-1 -: N]
- z_valid  in  1  one-cycle strobe: Z_in holds a complete tile
- bias  in  N  signed bias, sampled with the tile
- relu_en  in  1  ReLU enable, sampled with the tile
- out_ready  in  1  consumer accepts out_data this cycle
- clear_ovf  in  1  clears overflow
- out_data  out  N  post-processed element
- out_valid  out  1  out_data valid; held until accepted
- out_last  out  1  out_data is element SIZE*SIZE-1 of its tile
- out_idx  out  $clog2(SIZE*SIZE)  element index of out_data
- buf_full  out  1  both slots occupied
- overflow  out  1  sticky: a tile was dropped

## Operation
- Tile buffer:
  - Two slots, each holding tile data, bias and relu_en.
  - Pointers wr_ptr and rd_ptr (1 bit each); count 0..2.
- Capture:
  - A tile is accepted on z_valid when count<2, or when count==2 and the current tile is released in the same cycle.
  - An accepted tile is written to slot wr_ptr, and wr_ptr toggles.
  - Otherwise the tile is dropped and overflow is set.
- Output register:
  - Loads when the buffer is non-empty and (!out_valid || out_ready).
  - On load it takes element elem_cnt of slot rd_ptr, and elem_cnt increments.
  - out_idx = elem_cnt at load; out_last = (elem_cnt == SIZE*SIZE-1).
- Release:
  - Loading the last element releases the slot: rd_ptr toggles, count decrements, elem_cnt wraps to 0.
  - Simultaneous capture and release leaves count unchanged.
- Idle:
  - If out_valid && out_ready and the buffer is empty, out_valid drops to 0.
  - out_data, out_idx and out_last hold their last values.
- Post-processing:
  - sum = sext(Z) + sext(bias) in N+1 bits.
  - Result saturates to [-2^(N-1), 2^(N-1)-1].
  - Then, if relu_en and the result is negative, the output is 0.
- overflow:
  - Set by a drop; cleared by clear_ovf.
  - If a drop and clear_ovf occur in the same cycle, set wins.
- buf_full = (count==2), registered.
- Reset, mid-operation included, aborts any tile in flight without emitting further elements.

## Timing
- Reset values: out_data 0, out_valid 0, out_last 0, out_idx 0, buf_full 0, overflow 0; count, pointers and elem_cnt 0.
- Latency:
  - Tile accepted at edge t with the pipeline idle: element 0 is valid after edge t+1.
  - With out_ready held high, a tile drains in SIZE*SIZE consecutive cycles.
- Back-to-back tiles stream with no bubble while out_ready is high.
- While out_valid && !out_ready, out_data, out_idx and out_last are stable.
- A tile may arrive every cycle. Sustained input faster than one tile per SIZE*SIZE cycles overflows.

## Structure
- Shared package: default N/SIZE, IDX_W = $clog2(SIZE*SIZE), and a saturating signed add function reusable by other LeNet stages.
- One sub-module: drain_postproc. It is combinational: Z, bias and relu_en in, saturated/ReLU result out.
- Everything else (buffer, pointers, counters, output register) lives in the top module.

## Test plan
- Single tile, Z[k]=k, bias 0, relu off, out_ready=1:
  - 16 outputs 0..15 in order, out_idx 0..15.
  - out_last only on idx 15.
  - First out_valid one cycle after the capture edge.
- Saturation and ReLU, all with relu off unless stated:
  - Z=0x7FF0, bias 0x0020 gives 0x7FFF.
  - Z=0x8005, bias 0xFFF0 gives 0x8000.
  - Z=0xFFFD, bias 0, relu on gives 0x0000.
  - Z=0xFFFD, bias 0, relu off gives 0xFFFD.
- Backpressure with out_ready randomly toggled:
  - Data is held stable while stalled.
  - No element is lost or duplicated; order is preserved across two tiles with different bias.
- Overflow:
  - Three z_valid strobes 1 cycle apart with out_ready=0: buf_full=1 after the second; third is dropped and overflow=1.
  - Raise out_ready: exactly 32 elements emerge.
  - clear_ovf clears overflow.
- Simultaneous capture and release:
  - count==2, and z_valid coincides with the load of idx 15.
  - The new tile is accepted, overflow stays 0, and buf_full stays 1.
- Reset at idx 7 of a tile:
  - All outputs go to reset values immediately.
  - The next tile starts cleanly at idx 0.
